cond_ctrl: RTL and testbench

//  Sequences the execute-stage condition-flag register {N,Z,C,V}. Latches ALU flags on retiring
//  set_cond ops and tracks in-flight flag writers with a pending counter. Serves branch-condition

---
 rtl/cond_pkg.sv | 26 ++
 rtl/cond_ctrl_if.sv | 25 ++
 rtl/cond_eval.sv | 18 +
 rtl/cond_ctrl.sv | 68 ++++++
 tb/tb_cond_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: flag bit positions, condition codes and FSM states shared by the condition-flag logic
package cond_pkg;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
    localparam int DEF_MAX_INFLIGHT = 4;
    localparam int DEF_PEND_W = 3;
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
endpackage

// File: rtl/cond_ctrl_if.sv
// cond_ctrl_if: issue/retire/flush and branch-query signals between the pipeline and cond_ctrl
interface cond_ctrl_if;
    logic       issue_valid;
    logic       issue_set_cond;
    logic       issue_ready;
    logic       alu_valid;
    logic       alu_set_cond;
    logic [3:0] alu_flags;
    logic       flush;
    logic       br_req;
    logic [3:0] br_cc;
    logic       br_ack;
    logic       br_taken;
    logic       stall;
    logic [3:0] cond;
    logic       cond_err;
    modport master (
        output issue_valid, issue_set_cond, alu_valid, alu_set_cond, alu_flags, flush, br_req, br_cc,
        input  issue_ready, br_ack, br_taken, stall, cond, cond_err
    );
    modport slave (
        input  issue_valid, issue_set_cond, alu_valid, alu_set_cond, alu_flags, flush, br_req, br_cc,
        output issue_ready, br_ack, br_taken, stall, cond, cond_err
    );
endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational branch-condition evaluation of {N,Z,C,V} against a 4-bit condition code
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cc,
    output logic       taken
);
    logic n, z, c, v;
    logic [7:0] base;
    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];
    // even codes select a base condition; odd codes are its complement
    assign base = {1'b1, ~z & (n ~^ v), n ~^ v, c & ~z, v, n, c, z};
    assign taken = base[cc[3:1]] ^ cc[0];
endmodule

// File: rtl/cond_ctrl.sv
// cond_ctrl: condition-flag register, in-flight flag-writer tracking and branch-query sequencing
module cond_ctrl
    import cond_pkg::*;
#(
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int PEND_W = DEF_PEND_W
) (
    input logic         clk,
    input logic         rst,
    cond_ctrl_if.slave  bus
);
    logic [3:0]        cond_q, cond_d, cc_q, cc_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              err_q, err_d;
    state_t            state_q, state_d;
    logic              set_ret, issue_acc, taken;

    cond_eval u_eval (.flags(cond_q), .cc(cc_q), .taken(taken));

    assign bus.issue_ready = (pend_q < PEND_W'(MAX_INFLIGHT)) | set_ret;
    assign bus.br_ack = state_q == S_ACK;
    assign bus.br_taken = (state_q == S_ACK) & taken;
    assign bus.stall = state_q == S_WAIT;
    assign bus.cond = cond_q;
    assign bus.cond_err = err_q;

    // flag latch, pending counter and sticky underflow error
    always_comb begin
        set_ret = bus.alu_valid & bus.alu_set_cond;
        issue_acc = bus.issue_valid & bus.issue_set_cond & bus.issue_ready;
        cond_d = set_ret ? bus.alu_flags : cond_q;
        err_d = err_q | (set_ret & (pend_q == '0));
        pend_d = bus.flush ? '0 :
                 (issue_acc & ~set_ret) ? pend_q + PEND_W'(1) :
                 (set_ret & ~issue_acc & (pend_q != '0)) ? pend_q - PEND_W'(1) : pend_q;
    end

    // query FSM: a query is answered once no flag writer ahead of it is in flight
    always_comb begin
        state_d = state_q;
        cc_d = cc_q;
        case (state_q)
            S_IDLE: if (bus.br_req) begin
                cc_d = bus.br_cc;
                state_d = ((pend_q == '0) || ((pend_q == PEND_W'(1)) && set_ret)) ? S_ACK : S_WAIT;
            end
            S_WAIT: if (pend_d == '0) state_d = S_ACK;
            default: state_d = S_IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_q <= '0;
            cc_q <= '0;
            pend_q <= '0;
            err_q <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            cond_q <= cond_d;
            cc_q <= cc_d;
            pend_q <= pend_d;
            err_q <= err_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_cond_ctrl.sv
// tb_cond_ctrl: directed and random stimulus against a reference model, acks checked by a scoreboard
module tb_cond_ctrl;
    import cond_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cond_ctrl_if ifc ();
    cond_ctrl #(.MAX_INFLIGHT(4), .PEND_W(3)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct { int cyc; bit taken; } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    int         m_pend;
    logic [3:0] m_cond, q_cc, cc_hold;
    bit         m_err, m_wait, m_ack, req_hold;

    always @(posedge clk) cyc <= cyc + 1;

    // branch condition straight from the condition-code table
    function automatic bit ref_taken(input logic [3:0] f, input logic [3:0] cc);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // scoreboard monitor: every ack must match the queued expectation for this cycle
    always @(negedge clk) if (!done) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing br_ack at cycle %0d: got 0 expected 1", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (ifc.br_ack === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                miscompares++;
                $display("FAIL spurious br_ack at cycle %0d: got 1 expected 0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ifc.br_taken !== e.taken) begin
                    miscompares++;
                    $display("FAIL br_taken at cycle %0d: got %b expected %b", cyc, ifc.br_taken, e.taken);
                end
            end
        end
    end

    // one clock of stimulus: drive, check level outputs, advance the model
    task automatic tick(input bit r, input bit iv, input bit isc, input bit av, input bit asc,
                        input bit fl, input logic [3:0] flags);
        bit ret, acc, nxt, ack_now;
        int np;
        logic [3:0] nc;
        @(negedge clk);
        rst = r;
        ifc.issue_valid = iv; ifc.issue_set_cond = isc;
        ifc.alu_valid = av; ifc.alu_set_cond = asc; ifc.alu_flags = flags;
        ifc.flush = fl; ifc.br_req = req_hold; ifc.br_cc = cc_hold;
        #1;
        ret = av && asc;
        chk("issue_ready", {3'b0, ifc.issue_ready}, {3'b0, (m_pend < 4) || ret});
        chk("stall", {3'b0, ifc.stall}, {3'b0, m_wait});
        chk("cond", ifc.cond, m_cond);
        chk("cond_err", {3'b0, ifc.cond_err}, {3'b0, m_err});
        ack_now = m_ack;
        if (r) begin
            m_pend = 0; m_cond = '0; m_err = 0; m_wait = 0; m_ack = 0; q_cc = '0;
        end else begin
            acc = iv && isc && ((m_pend < 4) || ret);
            nc = ret ? flags : m_cond;
            if (ret && m_pend == 0) m_err = 1;
            np = fl ? 0 : (acc && !ret) ? m_pend + 1 : (ret && !acc && m_pend > 0) ? m_pend - 1 : m_pend;
            nxt = 0;
            if (!m_wait && !m_ack && req_hold) begin
                q_cc = cc_hold;
                if (m_pend == 0 || (m_pend == 1 && ret)) nxt = 1;
                else m_wait = 1;
            end else if (m_wait && np == 0) begin
                nxt = 1;
                m_wait = 0;
            end
            m_cond = nc; m_pend = np; m_ack = nxt;
            if (nxt) exp_q.push_back('{cyc + 1, ref_taken(nc, q_cc)});
        end
        if (ack_now) req_hold = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 4'h0);
    endtask

    task automatic query(input logic [3:0] cc);
        req_hold = 1; cc_hold = cc;
        idle(3);
    endtask

    initial begin
        bit iv, isc, av, asc, fl, r;
        rst = 1'b1;
        ifc.issue_valid = 0; ifc.issue_set_cond = 0; ifc.alu_valid = 0; ifc.alu_set_cond = 0;
        ifc.alu_flags = '0; ifc.flush = 0; ifc.br_req = 0; ifc.br_cc = '0;
        m_pend = 0; m_cond = '0; m_err = 0; m_wait = 0; m_ack = 0; q_cc = '0;
        req_hold = 0; cc_hold = '0;
        repeat (2) @(posedge clk);
        // 1: reset state, always/never conditions
        tick(1, 0, 0, 0, 0, 0, 4'h0);
        query(CC_AL);
        query(CC_NV);
        // 2: Z flag latched on retire
        tick(0, 1, 1, 0, 0, 0, 4'h0);
        tick(0, 0, 0, 1, 1, 0, 4'b0100);
        query(CC_EQ);
        query(CC_NE);
        // 3: query stalls behind two writers
        repeat (2) tick(0, 1, 1, 0, 0, 0, 4'h0);
        req_hold = 1; cc_hold = CC_GE;
        idle(3);
        tick(0, 0, 0, 1, 1, 0, 4'b1000);
        tick(0, 0, 0, 1, 1, 0, 4'b1001);
        idle(3);
        // 4: saturation at MAX_INFLIGHT, retire frees a slot in the same cycle
        repeat (4) tick(0, 1, 1, 0, 0, 0, 4'h0);
        tick(0, 1, 1, 0, 0, 0, 4'h0);
        tick(0, 1, 1, 1, 1, 0, 4'b0010);
        repeat (4) tick(0, 0, 0, 1, 1, 0, 4'b0010);
        // 5: flush releases a waiting query; reset abandons one
        repeat (3) tick(0, 1, 1, 0, 0, 0, 4'h0);
        req_hold = 1; cc_hold = CC_CS;
        idle(2);
        tick(0, 0, 0, 0, 0, 1, 4'h0);
        idle(3);
        repeat (2) tick(0, 1, 1, 0, 0, 0, 4'h0);
        req_hold = 1; cc_hold = CC_EQ;
        idle(2);
        req_hold = 0;
        tick(1, 0, 0, 0, 0, 0, 4'h0);
        idle(3);
        // 6: retire with nothing pending sets the sticky error
        tick(0, 0, 0, 1, 1, 0, 4'b1111);
        idle(3);
        query(CC_LE);
        tick(1, 0, 0, 0, 0, 0, 4'h0);
        idle(2);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (!req_hold && !m_wait && !m_ack && $urandom_range(0, 3) == 0) begin
                req_hold = 1;
                cc_hold = 4'($urandom);
            end
            iv = 1'($urandom);
            isc = 1'($urandom);
            av = 1'($urandom);
            asc = (m_pend > 0) && ($urandom_range(0, 2) != 0);
            fl = $urandom_range(0, 30) == 0;
            r = !m_ack && $urandom_range(0, 100) == 0;
            if (r) req_hold = 0;
            tick(r, iv, isc, av, asc, fl, 4'($urandom));
        end
        req_hold = 0;
        repeat (6) tick(0, 0, 0, 1, 1, 1, 4'h0);
        idle(4);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending acks at end: got %0d outstanding expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
